// File: rtl/parser_arb_pkg.sv
// Shared types and constants for the parser feed arbiter.
// Header length to payload-beat mapping lives here so every user agrees on it.
package parser_arb_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StHdr      = 2'd1,
        StPayload  = 2'd2,
        StWaitDone = 2'd3
    } arb_state_e;

    localparam int unsigned HdrThresh = 3;
    localparam int unsigned BeatW     = 8;

    // Short headers still carry one payload beat; longer ones exclude two framing bytes.
    function automatic logic [BeatW-1:0] hdr_to_beats(input logic [BeatW-1:0] len);
        if (len <= BeatW'(HdrThresh)) begin
            return BeatW'(1);
        end
        return len - BeatW'(2);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request selector: first asserted request at or after the pointer,
// wrapping around, returned as a one-hot grant.
module rr_arbiter #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned PtrW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o
);

    logic          found;
    logic [PtrW:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            idx = {1'b0, ptr_i} + (PtrW + 1)'(off);
            if (idx >= (PtrW + 1)'(NumReq)) begin
                idx = idx - (PtrW + 1)'(NumReq);
            end
            if (!found && req_i[idx[PtrW-1:0]]) begin
                gnt_o[idx[PtrW-1:0]] = 1'b1;
                found                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parser_feed_arbiter.sv
// Shares one message parser among several feed lanes: grants a lane round-robin,
// forwards its header then payload words, and waits for the parser to finish.
module parser_feed_arbiter
    import parser_arb_pkg::*;
#(
    parameter int unsigned NUM_LANES  = 4,
    parameter int unsigned DATA_WIDTH = 31,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                              clk_in,
    input  logic                              reset_in,
    input  logic [NUM_LANES*(DATA_WIDTH+1)-1:0] lane_data_in,
    input  logic [NUM_LANES-1:0]              lane_valid_in,
    output logic [NUM_LANES-1:0]              lane_ready_out,
    output logic [DATA_WIDTH:0]               parser_data_out,
    output logic                              parser_enable_out,
    output logic                              parser_valid_out,
    input  logic                              parser_ready_in,
    output logic [NUM_LANES-1:0]              grant_out,
    output logic                              busy_out,
    output logic                              timeout_err_out
);

    localparam int unsigned WordW = DATA_WIDTH + 1;
    localparam int unsigned PtrW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned CntW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e           state_q, state_d;
    logic [NUM_LANES-1:0] grant_q, grant_d;
    logic [PtrW-1:0]      ptr_q, ptr_d;
    logic [BeatW-1:0]     beats_q, beats_d;
    logic [CntW-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic                 tmo_err_q, tmo_err_d;

    logic [NUM_LANES-1:0] rr_gnt;
    logic [WordW-1:0]     g_word;
    logic [PtrW-1:0]      gidx;
    logic [PtrW-1:0]      ptr_nxt;
    logic                 active;
    logic                 xfer;

    rr_arbiter #(
        .NumReq (NUM_LANES),
        .PtrW   (PtrW)
    ) u_rr_arbiter (
        .req_i  (lane_valid_in),
        .ptr_i  (ptr_q),
        .gnt_o  (rr_gnt)
    );

    always_comb begin
        g_word = '0;
        gidx   = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (grant_q[i]) begin
                g_word = lane_data_in[i*WordW +: WordW];
                gidx   = PtrW'(i);
            end
        end
    end

    assign ptr_nxt = (gidx == PtrW'(NUM_LANES - 1)) ? '0 : gidx + PtrW'(1);
    assign active  = (state_q == StHdr) || (state_q == StPayload);
    assign xfer    = active && |(grant_q & lane_valid_in);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        beats_d   = beats_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|lane_valid_in) begin
                    grant_d = rr_gnt;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (xfer) begin
                    beats_d = hdr_to_beats(g_word[BeatW-1:0]);
                    state_d = StPayload;
                end
            end
            StPayload: begin
                if (xfer) begin
                    beats_d = beats_q - BeatW'(1);
                    if (beats_q == BeatW'(1)) begin
                        state_d   = StWaitDone;
                        tmo_cnt_d = '0;
                    end
                end
            end
            StWaitDone: begin
                // Completion wins over a coincident timeout.
                if (parser_ready_in || (tmo_cnt_q == CntW'(TIMEOUT - 1))) begin
                    state_d   = StIdle;
                    grant_d   = '0;
                    ptr_d     = ptr_nxt;
                    tmo_cnt_d = '0;
                    tmo_err_d = !parser_ready_in;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            ptr_q     <= '0;
            beats_q   <= '0;
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            beats_q   <= beats_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign lane_ready_out    = active ? (grant_q & lane_valid_in) : '0;
    assign parser_data_out   = active ? g_word : '0;
    assign parser_enable_out = xfer && (state_q == StHdr);
    assign parser_valid_out  = xfer && (state_q == StPayload);
    assign grant_out         = grant_q;
    assign busy_out          = (state_q != StIdle);
    assign timeout_err_out   = tmo_err_q;

endmodule
